mpipe_skid: RTL and testbench

//  E->M pipeline register on the receiving side of the EXU handshake: accepts e_valid_o/res_o/cnd_o
//  and drives M_ready_i back to the EXU. It holds the EXU result and the side info the memory stage

---
 rtl/mpipe_skid_pkg.sv | 7 +
 rtl/mpipe_skid_buf.sv | 48 ++++
 rtl/mpipe_skid.sv | 45 ++++
 tb/tb_mpipe_skid.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mpipe_skid_pkg.sv
// mpipe_skid_pkg: shared E->M widths and the packed payload width
package mpipe_skid_pkg;
  localparam int XLEN     = 32;
  localparam int OPINFO_W = 16;
  localparam int RD_W     = 5;
  localparam int E2M_W    = 3 * XLEN + 1 + OPINFO_W + RD_W;
endpackage

// File: rtl/mpipe_skid_buf.sv
// skid_buf: generic two-entry valid/ready slice with registered ready and a synchronous clear
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic         r_main_v;
  logic         r_skid_v;
  logic [W-1:0] r_main_d;
  logic [W-1:0] r_skid_d;
  logic         w_acc;
  logic         w_drn;
  assign o_ready = ~r_skid_v;
  assign o_valid = r_main_v;
  assign o_data  = r_main_d;
  assign w_acc   = i_valid & ~r_skid_v & ~i_clr;
  assign w_drn   = r_main_v & i_ready;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= '0;
      r_skid_d <= '0;
    end else if (i_clr) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (r_skid_v) begin
      if (w_drn) begin
        r_main_d <= r_skid_d;
        r_skid_v <= 1'b0;
      end
    end else if (!r_main_v || w_drn) begin
      r_main_v <= w_acc;
      if (w_acc) r_main_d <= i_data;
    end else if (w_acc) begin
      r_skid_v <= 1'b1;
      r_skid_d <= i_data;
    end
  end
endmodule

// File: rtl/mpipe_skid.sv
// mpipe_skid: E->M pipeline skid register between EXU and MEM with flush
module mpipe_skid
  import mpipe_skid_pkg::*;
#(
  parameter int XLEN_P     = XLEN,
  parameter int OPINFO_W_P = OPINFO_W,
  parameter int RD_W_P     = RD_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush_i,
  input  logic                  e_valid_i,
  output logic                  M_ready_o,
  input  logic [XLEN_P-1:0]     e_pc_i,
  input  logic [XLEN_P-1:0]     e_res_i,
  input  logic [XLEN_P-1:0]     e_src2_i,
  input  logic                  e_cnd_i,
  input  logic [OPINFO_W_P-1:0] e_opinfo_i,
  input  logic [RD_W_P-1:0]     e_rd_i,
  output logic                  M_valid_o,
  input  logic                  m_ready_i,
  output logic [XLEN_P-1:0]     M_pc_o,
  output logic [XLEN_P-1:0]     M_res_o,
  output logic [XLEN_P-1:0]     M_src2_o,
  output logic                  M_cnd_o,
  output logic [OPINFO_W_P-1:0] M_opinfo_o,
  output logic [RD_W_P-1:0]     M_rd_o
);
  localparam int PW = 3 * XLEN_P + 1 + OPINFO_W_P + RD_W_P;
  logic [PW-1:0] w_in;
  logic [PW-1:0] w_out;
  assign w_in = {e_pc_i, e_res_i, e_src2_i, e_cnd_i, e_opinfo_i, e_rd_i};
  assign {M_pc_o, M_res_o, M_src2_o, M_cnd_o, M_opinfo_o, M_rd_o} = w_out;
  skid_buf #(.W(PW)) u_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clr   (flush_i),
    .i_valid (e_valid_i),
    .o_ready (M_ready_o),
    .i_data  (w_in),
    .o_valid (M_valid_o),
    .i_ready (m_ready_i),
    .o_data  (w_out)
  );
endmodule

// File: tb/tb_mpipe_skid.sv
// tb_mpipe_skid: directed and randomized checks of the E->M skid register
module tb_mpipe_skid;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        e_valid_i = 1'b0;
  logic        M_ready_o;
  logic [31:0] e_pc_i = '0;
  logic [31:0] e_res_i = '0;
  logic [31:0] e_src2_i = '0;
  logic        e_cnd_i = 1'b0;
  logic [15:0] e_opinfo_i = '0;
  logic [4:0]  e_rd_i = '0;
  logic        M_valid_o;
  logic        m_ready_i = 1'b0;
  logic [31:0] M_pc_o;
  logic [31:0] M_res_o;
  logic [31:0] M_src2_o;
  logic        M_cnd_o;
  logic [15:0] M_opinfo_o;
  logic [4:0]  M_rd_o;
  int n_cmp = 0;
  int n_bad = 0;

  mpipe_skid dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush_i    (flush_i),
    .e_valid_i  (e_valid_i),
    .M_ready_o  (M_ready_o),
    .e_pc_i     (e_pc_i),
    .e_res_i    (e_res_i),
    .e_src2_i   (e_src2_i),
    .e_cnd_i    (e_cnd_i),
    .e_opinfo_i (e_opinfo_i),
    .e_rd_i     (e_rd_i),
    .M_valid_o  (M_valid_o),
    .m_ready_i  (m_ready_i),
    .M_pc_o     (M_pc_o),
    .M_res_o    (M_res_o),
    .M_src2_o   (M_src2_o),
    .M_cnd_o    (M_cnd_o),
    .M_opinfo_o (M_opinfo_o),
    .M_rd_o     (M_rd_o)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r);
    e_valid_i  = v;
    e_res_i    = r;
    e_pc_i     = r ^ 32'hFFFF_0000;
    e_src2_i   = {r[15:0], r[31:16]};
    e_cnd_i    = r[0];
    e_opinfo_i = r[15:0] ^ 16'h5A5A;
    e_rd_i     = r[4:0];
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h1234);
    m_ready_i = 1'b1;
    tick();
    tick();
    n_cmp++; if (M_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", M_valid_o); end
    n_cmp++; if (M_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", M_ready_o); end
    n_cmp++; if (M_res_o !== 32'h0 || M_pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_payload res=%h pc=%h exp=0", M_res_o, M_pc_o); end
    reset_n = 1'b1;
    tick();
    n_cmp++; if (M_valid_o !== 1'b1 || M_res_o !== 32'h1234) begin n_bad++; $display("FAIL first_beat v=%b res=%h exp=1/1234", M_valid_o, M_res_o); end
    n_cmp++; if (M_pc_o !== 32'hFFFF_1234 || M_rd_o !== 5'h14) begin n_bad++; $display("FAIL first_side pc=%h rd=%h exp=ffff1234/14", M_pc_o, M_rd_o); end
    drive(1'b0, 32'h0);
    tick();
    n_cmp++; if (M_valid_o !== 1'b0) begin n_bad++; $display("FAIL first_drain got=%b exp=0", M_valid_o); end
  endtask

  task automatic test_back_to_back();
    m_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i));
      tick();
      n_cmp++; if (M_valid_o !== 1'b1 || M_res_o !== 32'(i) || M_ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_%0d v=%b rdy=%b res=%h exp=1/1/%h", i, M_valid_o, M_ready_o, M_res_o, 32'(i)); end
    end
    n_cmp++; if (M_src2_o !== 32'h0008_0000 || M_opinfo_o !== 16'h5A52 || M_cnd_o !== 1'b0) begin n_bad++; $display("FAIL b2b_side src2=%h op=%h cnd=%b exp=00080000/5a52/0", M_src2_o, M_opinfo_o, M_cnd_o); end
    drive(1'b0, 32'h0);
    tick();
    n_cmp++; if (M_valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_end got=%b exp=0", M_valid_o); end
  endtask

  task automatic test_stall();
    m_ready_i = 1'b0;
    drive(1'b1, 32'hA);
    tick();
    n_cmp++; if (M_ready_o !== 1'b1 || M_res_o !== 32'hA) begin n_bad++; $display("FAIL stall_a rdy=%b res=%h exp=1/a", M_ready_o, M_res_o); end
    drive(1'b1, 32'hB);
    tick();
    n_cmp++; if (M_ready_o !== 1'b0 || M_valid_o !== 1'b1 || M_res_o !== 32'hA) begin n_bad++; $display("FAIL stall_full rdy=%b v=%b res=%h exp=0/1/a", M_ready_o, M_valid_o, M_res_o); end
    drive(1'b1, 32'hC);
    tick();
    n_cmp++; if (M_ready_o !== 1'b0 || M_res_o !== 32'hA) begin n_bad++; $display("FAIL stall_hold rdy=%b res=%h exp=0/a", M_ready_o, M_res_o); end
    m_ready_i = 1'b1;
    tick();
    n_cmp++; if (M_valid_o !== 1'b1 || M_res_o !== 32'hB || M_ready_o !== 1'b1) begin n_bad++; $display("FAIL stall_b v=%b rdy=%b res=%h exp=1/1/b", M_valid_o, M_ready_o, M_res_o); end
    tick();
    n_cmp++; if (M_valid_o !== 1'b1 || M_res_o !== 32'hC) begin n_bad++; $display("FAIL stall_c v=%b res=%h exp=1/c", M_valid_o, M_res_o); end
    drive(1'b0, 32'h0);
    tick();
    n_cmp++; if (M_valid_o !== 1'b0 || M_ready_o !== 1'b1) begin n_bad++; $display("FAIL stall_end v=%b rdy=%b exp=0/1", M_valid_o, M_ready_o); end
  endtask

  task automatic test_flush();
    m_ready_i = 1'b0;
    drive(1'b1, 32'hE);
    tick();
    drive(1'b1, 32'hF);
    tick();
    n_cmp++; if (M_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_pre rdy=%b exp=0", M_ready_o); end
    flush_i = 1'b1;
    drive(1'b1, 32'hD);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0);
    n_cmp++; if (M_valid_o !== 1'b0 || M_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_post v=%b rdy=%b exp=0/1", M_valid_o, M_ready_o); end
    m_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (M_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_ghost_%0d v=%b res=%h exp=0", i, M_valid_o, M_res_o); end
    end
  endtask

  task automatic test_async_reset();
    m_ready_i = 1'b0;
    drive(1'b1, 32'h11);
    tick();
    drive(1'b1, 32'h22);
    tick();
    drive(1'b0, 32'h0);
    n_cmp++; if (M_valid_o !== 1'b1 || M_ready_o !== 1'b0) begin n_bad++; $display("FAIL areset_pre v=%b rdy=%b exp=1/0", M_valid_o, M_ready_o); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (M_valid_o !== 1'b0 || M_ready_o !== 1'b1 || M_res_o !== 32'h0) begin n_bad++; $display("FAIL areset v=%b rdy=%b res=%h exp=0/1/0", M_valid_o, M_ready_o, M_res_o); end
    tick();
    reset_n = 1'b1;
    m_ready_i = 1'b1;
    tick();
    n_cmp++; if (M_valid_o !== 1'b0) begin n_bad++; $display("FAIL areset_after v=%b exp=0", M_valid_o); end
  endtask

  task automatic test_stress();
    logic [31:0] q[$];
    logic [31:0] cur = '0;
    logic [31:0] exp_r;
    logic        pend = 1'b0;
    logic        rdy_snap;
    for (int c = 0; c < 10000; c++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        cur  = $urandom;
        pend = 1'b1;
      end
      drive(pend, cur);
      m_ready_i = ($urandom_range(0, 2) != 0);
      #1;
      n_cmp++; if (M_valid_o !== (q.size() != 0)) begin n_bad++; $display("FAIL stress_valid c=%0d got=%b exp=%b", c, M_valid_o, q.size() != 0); end
      n_cmp++; if (M_ready_o !== (q.size() < 2)) begin n_bad++; $display("FAIL stress_ready c=%0d got=%b exp=%b", c, M_ready_o, q.size() < 2); end
      rdy_snap = M_ready_o;
      m_ready_i = ~m_ready_i;
      #1;
      n_cmp++; if (M_ready_o !== rdy_snap) begin n_bad++; $display("FAIL stress_comb_ready c=%0d got=%b exp=%b", c, M_ready_o, rdy_snap); end
      m_ready_i = ~m_ready_i;
      #1;
      if (M_valid_o && m_ready_i && q.size() != 0) begin
        exp_r = q.pop_front();
        n_cmp++; if (M_res_o !== exp_r || M_rd_o !== exp_r[4:0] || M_pc_o !== (exp_r ^ 32'hFFFF_0000)) begin n_bad++; $display("FAIL stress_data c=%0d res=%h rd=%h pc=%h exp_res=%h", c, M_res_o, M_rd_o, M_pc_o, exp_r); end
      end
      if (pend && M_ready_o) begin
        q.push_back(cur);
        pend = 1'b0;
      end
      tick();
    end
    drive(1'b0, 32'h0);
    m_ready_i = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++; if (M_valid_o !== 1'b0) begin n_bad++; $display("FAIL stress_drain v=%b exp=0", M_valid_o); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_stress();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
